// File: rtl/cart_pkg.sv
// rtl/cart_pkg.sv - shared cartridge types and ASCII8 mapper constants
package cart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_FINISH
  } loader_state_t;

  localparam logic [7:0]  OP_LD_NN_A   = 8'h32;
  localparam logic [15:0] ASCII8_BANK0 = 16'h6000;
  localparam logic [15:0] ASCII8_BANK1 = 16'h6800;
  localparam logic [15:0] ASCII8_BANK2 = 16'h7000;
  localparam logic [15:0] ASCII8_BANK3 = 16'h7800;

  function automatic logic is_ascii8_bank_addr(input logic [15:0] addr);
    return (addr == ASCII8_BANK0) || (addr == ASCII8_BANK1) ||
           (addr == ASCII8_BANK2) || (addr == ASCII8_BANK3);
  endfunction

endpackage

// File: rtl/cart_ascii8_detect.sv
// rtl/cart_ascii8_detect.sv - counts LD (nn),A writes to ASCII8 bank registers
module cart_ascii8_detect
  import cart_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       strobe,
  input  logic [7:0] data,
  output logic [7:0] hits
);

  logic [7:0] b1_q;
  logic [7:0] b2_q;
  logic [7:0] hits_q;
  logic [7:0] hits_d;
  logic       match;

  // Operand is little-endian: the current byte is the high half of nn.
  assign match = (b2_q == OP_LD_NN_A) && is_ascii8_bank_addr({data, b1_q});

  always_comb begin
    hits_d = hits_q;
    if (strobe && match && (hits_q != 8'hFF)) begin
      hits_d = hits_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      b1_q   <= 8'h00;
      b2_q   <= 8'h00;
      hits_q <= 8'h00;
    end else if (strobe) begin
      b2_q   <= b1_q;
      b1_q   <= data;
      hits_q <= hits_d;
    end
  end

  assign hits = hits_q;

endmodule

// File: rtl/cart_rom_loader.sv
// rtl/cart_rom_loader.sv - writes an ioctl cartridge image to SDRAM and publishes rom_size
module cart_rom_loader
  import cart_pkg::*;
#(
  parameter logic [24:0] CART_BASE0 = 25'h0000000,
  parameter logic [24:0] CART_BASE1 = 25'h0400000,
  parameter logic [24:0] MAX_SIZE   = 25'h0400000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  input  logic        cart_num,
  output logic [24:0] ram_addr,
  output logic [7:0]  ram_din,
  output logic        ram_we,
  input  logic        ram_ack,
  output logic [24:0] rom_size0,
  output logic [24:0] rom_size1,
  output logic [7:0]  ascii8_hits,
  output logic        overflow,
  output logic        load_done
);

  loader_state_t state_q;
  logic          cart_q;
  logic [24:0]   max_q;
  logic          wait_q;
  logic [24:0]   ram_addr_q;
  logic [7:0]    ram_din_q;
  logic          ram_we_q;
  logic [24:0]   rom_size0_q;
  logic [24:0]   rom_size1_q;
  logic [7:0]    hits_pub_q;
  logic          overflow_q;
  logic          load_done_q;

  logic          in_window;
  logic          det_clear;
  logic          det_strobe;
  logic [7:0]    det_hits;
  logic [24:0]   base;

  assign in_window  = ioctl_addr < MAX_SIZE;
  assign base       = cart_q ? CART_BASE1 : CART_BASE0;
  assign det_clear  = (state_q == ST_IDLE) && ioctl_download;
  // Out-of-window bytes still feed the heuristic; strobes during WRITE do not.
  assign det_strobe = (state_q == ST_LOAD) && ioctl_wr;

  cart_ascii8_detect u_detect (
    .clk    (clk),
    .reset  (reset),
    .clear  (det_clear),
    .strobe (det_strobe),
    .data   (ioctl_dout),
    .hits   (det_hits)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cart_q      <= 1'b0;
      max_q       <= 25'd0;
      wait_q      <= 1'b0;
      ram_addr_q  <= 25'd0;
      ram_din_q   <= 8'h00;
      ram_we_q    <= 1'b0;
      rom_size0_q <= 25'd0;
      rom_size1_q <= 25'd0;
      hits_pub_q  <= 8'h00;
      overflow_q  <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ioctl_download) begin
            state_q    <= ST_LOAD;
            cart_q     <= cart_num;
            max_q      <= 25'd0;
            overflow_q <= 1'b0;
          end
        end
        ST_LOAD: begin
          // A strobe coincident with download falling is still written.
          if (ioctl_wr && in_window) begin
            ram_addr_q <= base + ioctl_addr;
            ram_din_q  <= ioctl_dout;
            ram_we_q   <= 1'b1;
            wait_q     <= 1'b1;
            if (ioctl_addr > max_q) begin
              max_q <= ioctl_addr;
            end
            state_q <= ST_WRITE;
          end else begin
            if (ioctl_wr) begin
              overflow_q <= 1'b1;
            end
            if (!ioctl_download) begin
              state_q <= ST_FINISH;
            end
          end
        end
        ST_WRITE: begin
          if (ram_ack) begin
            ram_we_q <= 1'b0;
            wait_q   <= 1'b0;
            state_q  <= ST_LOAD;
          end
        end
        ST_FINISH: begin
          if (cart_q) begin
            rom_size1_q <= max_q;
          end else begin
            rom_size0_q <= max_q;
          end
          hits_pub_q  <= det_hits;
          load_done_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ioctl_wait  = wait_q;
  assign ram_addr    = ram_addr_q;
  assign ram_din     = ram_din_q;
  assign ram_we      = ram_we_q;
  assign rom_size0   = rom_size0_q;
  assign rom_size1   = rom_size1_q;
  assign ascii8_hits = hits_pub_q;
  assign overflow    = overflow_q;
  assign load_done   = load_done_q;

endmodule

// File: tb/tb_cart_rom_loader.sv
// tb/tb_cart_rom_loader.sv - directed self-checking bench for cart_rom_loader
module tb_cart_rom_loader;

  localparam logic [24:0] B0  = 25'h0000000;
  localparam logic [24:0] B1  = 25'h0400000;
  localparam logic [24:0] MAX = 25'h0000200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait;
  logic        cart_num = 1'b0;
  logic [24:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic        ram_ack = 1'b0;
  logic [24:0] rom_size0;
  logic [24:0] rom_size1;
  logic [7:0]  ascii8_hits;
  logic        overflow;
  logic        load_done;

  int checks = 0;
  int failures = 0;
  int wr_err = 0;
  int wr_cnt = 0;
  int ack_lat = 3;
  int done_cnt = 0;
  int ack_cnt = 0;
  int done_base;
  int ack_base;

  always #5 clk = ~clk;

  cart_rom_loader #(
    .CART_BASE0 (B0),
    .CART_BASE1 (B1),
    .MAX_SIZE   (MAX)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .cart_num       (cart_num),
    .ram_addr       (ram_addr),
    .ram_din        (ram_din),
    .ram_we         (ram_we),
    .ram_ack        (ram_ack),
    .rom_size0      (rom_size0),
    .rom_size1      (rom_size1),
    .ascii8_hits    (ascii8_hits),
    .overflow       (overflow),
    .load_done      (load_done)
  );

  always @(posedge clk) begin
    if (load_done) done_cnt <= done_cnt + 1;
    if (ram_we && ram_ack) ack_cnt <= ack_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_load(input logic c);
    @(negedge clk);
    cart_num = c;
    ioctl_download = 1'b1;
    @(negedge clk);
    wr_err = 0;
    wr_cnt = 0;
    done_base = done_cnt;
    ack_base = ack_cnt;
  endtask

  task automatic end_load();
    @(negedge clk);
    ioctl_download = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // One strobe; in-window bytes are acked ack_lat cycles after ram_we rises.
  task automatic send_byte(input logic [24:0] addr, input logic [7:0] data, input logic [24:0] base);
    @(negedge clk);
    ioctl_wr = 1'b1;
    ioctl_addr = addr;
    ioctl_dout = data;
    @(negedge clk);
    ioctl_wr = 1'b0;
    if (addr < MAX) begin
      if (!ram_we || !ioctl_wait) begin
        wr_err++;
      end else begin
        repeat (ack_lat - 1) @(negedge clk);
        if (!ram_we || ram_addr !== base + addr || ram_din !== data) wr_err++;
        ram_ack = 1'b1;
        @(negedge clk);
        ram_ack = 1'b0;
        if (ram_we || ioctl_wait) wr_err++;
        wr_cnt++;
      end
    end else begin
      if (ram_we || ioctl_wait) wr_err++;
    end
  endtask

  logic [7:0] img2 [9];

  initial begin
    img2 = '{8'h00, 8'h32, 8'h00, 8'h68, 8'h11, 8'h32, 8'h00, 8'h78, 8'h22};

    repeat (3) @(negedge clk);
    check("rst_ram_we", ram_we, 0);
    check("rst_wait", ioctl_wait, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_din", ram_din, 0);
    check("rst_size0", rom_size0, 0);
    check("rst_size1", rom_size1, 0);
    check("rst_hits", ascii8_hits, 0);
    check("rst_overflow", overflow, 0);
    check("rst_done", load_done, 0);
    reset = 1'b0;

    // Fill cart 0 window, then one byte at MAX
    ack_lat = 3;
    start_load(1'b0);
    for (int i = 0; i < 512; i++) send_byte(i[24:0], i[7:0], B0);
    send_byte(MAX, 8'h99, B0);
    end_load();
    check("fill_wr_err", wr_err, 0);
    check("fill_wr_cnt", wr_cnt, 512);
    check("fill_acks", ack_cnt - ack_base, 512);
    check("fill_size0", rom_size0, 25'h1FF);
    check("fill_size1", rom_size1, 0);
    check("fill_overflow", overflow, 1);
    check("fill_hits", ascii8_hits, 0);
    check("fill_done", done_cnt - done_base, 1);

    // Two ASCII8 bank writes to cart 1
    ack_lat = 2;
    start_load(1'b1);
    for (int i = 0; i < 9; i++) send_byte(i[24:0], img2[i], B1);
    end_load();
    check("a8_wr_err", wr_err, 0);
    check("a8_hits", ascii8_hits, 2);
    check("a8_size1", rom_size1, 25'h8);
    check("a8_size0", rom_size0, 25'h1FF);
    check("a8_overflow", overflow, 0);
    check("a8_done", done_cnt - done_base, 1);

    // Empty download
    start_load(1'b1);
    end_load();
    check("empty_size1", rom_size1, 0);
    check("empty_size0", rom_size0, 25'h1FF);
    check("empty_hits", ascii8_hits, 0);
    check("empty_done", done_cnt - done_base, 1);

    // 300 hit patterns; tail beyond the window still counts
    ack_lat = 1;
    start_load(1'b1);
    for (int i = 0; i < 900; i++) begin
      case (i % 3)
        0: send_byte(i[24:0], 8'h32, B1);
        1: send_byte(i[24:0], 8'h00, B1);
        default: send_byte(i[24:0], 8'h68, B1);
      endcase
    end
    end_load();
    check("sat_wr_err", wr_err, 0);
    check("sat_acks", ack_cnt - ack_base, 512);
    check("sat_hits", ascii8_hits, 8'hFF);
    check("sat_size1", rom_size1, 25'h1FF);
    check("sat_overflow", overflow, 1);

    // Download drops while a write is pending; a strobe during WRITE is ignored
    start_load(1'b0);
    @(negedge clk);
    ioctl_wr = 1'b1;
    ioctl_addr = 25'h10;
    ioctl_dout = 8'h5A;
    @(negedge clk);
    ioctl_wr = 1'b1;
    ioctl_addr = 25'h30;
    ioctl_dout = 8'hAA;
    ioctl_download = 1'b0;
    check("drop_we_rise", ram_we, 1);
    @(negedge clk);
    ioctl_wr = 1'b0;
    repeat (3) @(negedge clk);
    check("drop_we_held", ram_we, 1);
    check("drop_addr", ram_addr, 25'h10);
    check("drop_din", ram_din, 8'h5A);
    check("drop_no_done", done_cnt - done_base, 0);
    ram_ack = 1'b1;
    @(negedge clk);
    ram_ack = 1'b0;
    check("drop_we_fall", ram_we, 0);
    repeat (4) @(negedge clk);
    check("drop_acks", ack_cnt - ack_base, 1);
    check("drop_done", done_cnt - done_base, 1);
    check("drop_size0", rom_size0, 25'h10);
    check("drop_overflow", overflow, 0);

    // Reset in the middle of a write
    start_load(1'b0);
    @(negedge clk);
    ioctl_wr = 1'b1;
    ioctl_addr = 25'h0;
    ioctl_dout = 8'h11;
    @(negedge clk);
    ioctl_wr = 1'b0;
    check("mid_we", ram_we, 1);
    reset = 1'b1;
    ioctl_download = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("mrst_we", ram_we, 0);
    check("mrst_wait", ioctl_wait, 0);
    check("mrst_size0", rom_size0, 0);
    check("mrst_size1", rom_size1, 0);
    repeat (3) @(negedge clk);
    check("mrst_no_done", done_cnt - done_base, 0);

    // Fresh load after reset
    ack_lat = 2;
    start_load(1'b0);
    send_byte(25'h0, 8'h32, B0);
    send_byte(25'h1, 8'h00, B0);
    send_byte(25'h2, 8'h70, B0);
    send_byte(25'h3, 8'h00, B0);
    end_load();
    check("fresh_wr_err", wr_err, 0);
    check("fresh_size0", rom_size0, 25'h3);
    check("fresh_size1", rom_size1, 0);
    check("fresh_hits", ascii8_hits, 1);
    check("fresh_done", done_cnt - done_base, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cart_rom_loader.md
Name: cart_rom_loader

Overview:
- Write side of the cartridge ROM path: accepts the HPS ioctl byte stream for a cartridge image, writes it into SDRAM at the slot's base address via a req/ack handshake, and publishes the per-cartridge rom_size that the mapper uses for unmapped-address detection.
- Also runs the ASCII8 bank-write heuristic over the image (LD (nn),A to 6000h/6800h/7000h/7800h) so the slot layer can select a mapper.
- Sits between the ioctl download port and the SDRAM arbiter, beside the slot/mapper blocks.

Parameters:
CART_BASE0, 25'h0000000, SDRAM byte base address of cartridge 0
CART_BASE1, 25'h0400000, SDRAM byte base address of cartridge 1
MAX_SIZE, 25'h0400000, maximum image bytes per cartridge; bytes at offset >= MAX_SIZE are dropped

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ioctl_download  in  1  high for the duration of an image transfer
ioctl_wr  in  1  one-cycle strobe: ioctl_dout valid at offset ioctl_addr
ioctl_addr  in  25  byte offset within the image
ioctl_dout  in  8  image byte
ioctl_wait  out  1  back-pressure to the HPS; no new strobe accepted while high
cart_num  in  1  target cartridge, sampled on download start
ram_addr  out  25  SDRAM byte address
ram_din  out  8  SDRAM write data
ram_we  out  1  write request, held until ram_ack
ram_ack  in  1  one-cycle acknowledge from the arbiter
rom_size0  out  25  cart 0 highest valid byte offset (size-1)
rom_size1  out  25  cart 1 highest valid byte offset (size-1)
ascii8_hits  out  8  saturating heuristic count for the last completed load
overflow  out  1  sticky: the last load contained bytes at offset >= MAX_SIZE
load_done  out  1  one-cycle pulse when a load completes

Behaviour:
- Reset: state IDLE. All outputs are 0: ioctl_wait, ram_we, ram_addr, ram_din, rom_size0/1, ascii8_hits, overflow, load_done. Heuristic shift state is cleared.
- FSM states: IDLE, LOAD, WRITE, FINISH.
- IDLE -> LOAD on ioctl_download=1. In the same cycle: latch cart_num, clear the running max offset, clear the hit counter and overflow, clear the heuristic history.
- LOAD with ioctl_wr=1 and ioctl_addr < MAX_SIZE:
  - ram_addr <= base + ioctl_addr and ram_din <= ioctl_dout.
  - ram_we <= 1 and ioctl_wait <= 1; go to WRITE. Outputs are registered, so ram_we rises the cycle after the strobe.
  - Running max offset <= max(max, ioctl_addr).
- LOAD with ioctl_wr=1 and ioctl_addr >= MAX_SIZE: no SDRAM write, no stall; overflow <= 1. The byte still feeds the heuristic.
- WRITE: hold ram_addr, ram_din and ram_we until ram_ack=1. That cycle: ram_we <= 0, ioctl_wait <= 0, return to LOAD. Minimum two cycles per byte.
- ioctl_wr asserted while in WRITE is ignored.
- LOAD with ioctl_download=0 -> FINISH. If download drops while in WRITE, finish the pending write first, then go to FINISH.
- FINISH (one cycle):
  - rom_sizeN <= running max for the latched cart; the other cart's size is unchanged.
  - Publish the hit count to ascii8_hits; load_done=1; go to IDLE.
- Empty download (no strobes): rom_sizeN <= 0 and load_done still pulses.
- Heuristic:
  - Keep the last two bytes (b1 = previous, b2 = one before).
  - On each accepted strobe: if b2 = 8'h32 and {ioctl_dout, b1} is one of 16'h6000, 6800, 7000 or 7800, increment the hit counter, saturating at 8'hFF.
  - Strobes must be address-contiguous; non-contiguous offsets are not tracked.
- ioctl_download rising again while in FINISH is handled in IDLE on the next cycle.
- Reset mid-load: immediate return to IDLE. ram_we drops the next cycle with no completion wait; rom_size values return to 0.

Decomposition:
- Shared package (cart_pkg): loader_state_t enum; the ASCII8 bank-register address constants (6000h/6800h/7000h/7800h) used by both mapper and loader; the LD (nn),A opcode constant 8'h32.
- One natural sub-module: cart_ascii8_detect (byte history, pattern match, saturating counter), with ports clk, reset, clear, strobe, data, hits.

Test Plan:
- Load 32 KiB to cart 0, ram_ack 3 cycles after each ram_we -> 32768 writes to 0x0000000..0x0007FFF, rom_size0=25'h7FFF, one load_done pulse, rom_size1 unchanged.
- Image containing 32 00 68 and 32 00 78, loaded to cart 1 -> ascii8_hits=2, writes at CART_BASE1+offset, rom_size1 = bytes-1.
- Image with 300 hit patterns -> ascii8_hits=8'hFF (saturated).
- Strobe at ioctl_addr=MAX_SIZE -> no ram_we, ioctl_wait stays 0, overflow=1 after completion, rom_size = MAX_SIZE-1 if the preceding bytes filled the window.
- ioctl_download drops while ram_we is pending, ack 5 cycles later -> write completes, then FINISH, then load_done; no lost byte.
- Reset asserted mid-WRITE -> next cycle ram_we=0, ioctl_wait=0, rom_size0/1=0, FSM in IDLE; a fresh load then completes normally.
